seq_request_scheduler: RTL and testbench

//  Shares one sequence-term engine among NUM_REQ requesters. Each requester asks for term n of the sequence
//  a(0)=0, a(1)=1, a(2)=1, a(n)=a(n-2)+a(n-3).

---
 rtl/seq_sched_pkg.sv | 16 +
 rtl/seq_step_engine.sv | 43 ++++
 rtl/seq_request_scheduler.sv | 141 ++++++++++++++
 tb/tb_seq_request_scheduler.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_sched_pkg.sv
// Shared definitions for the sequence request scheduler.
//   state_t      : scheduler FSM states
//   SEED0..SEED2 : first three sequence terms a(0), a(1), a(2)
package seq_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int SEED0 = 0;
    localparam int SEED1 = 1;
    localparam int SEED2 = 1;

endpackage

// File: rtl/seq_step_engine.sv
// Three-term sliding window over a(n)=a(n-2)+a(n-3).
// Ports:
//   i_clk    : clock, rising edge
//   i_reset  : asynchronous active-high reset, clears the window
//   i_load   : reload window with {a(0),a(1),a(2)} (wins over i_step)
//   i_step   : advance window by one term
//   o_term   : current oldest term of the window (a0)
module seq_step_engine
    import seq_sched_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic             i_step,
    output logic [WIDTH-1:0] o_term
);

    logic [WIDTH-1:0] r_a0;
    logic [WIDTH-1:0] r_a1;
    logic [WIDTH-1:0] r_a2;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_a0 <= '0;
            r_a1 <= '0;
            r_a2 <= '0;
        end else if (i_load) begin
            r_a0 <= WIDTH'(SEED0);
            r_a1 <= WIDTH'(SEED1);
            r_a2 <= WIDTH'(SEED2);
        end else if (i_step) begin
            // a(n+3) = a(n+1) + a(n); the sum wraps at 2^WIDTH
            r_a0 <= r_a1;
            r_a1 <= r_a2;
            r_a2 <= r_a0 + r_a1;
        end
    end

    assign o_term = r_a0;

endmodule

// File: rtl/seq_request_scheduler.sv
// Round-robin scheduler sharing one sequence-term engine among NUM_REQ clients.
// Ports:
//   i_clk        : clock, rising edge
//   i_reset      : asynchronous active-high reset
//   i_req_valid  : per-requester request valid
//   i_req_idx    : per-requester term index, slice i = [i*IDX_W +: IDX_W]
//   o_req_ready  : one-hot grant, only in IDLE
//   o_rsp_valid  : response valid (held until i_rsp_ready)
//   i_rsp_ready  : response consumer ready
//   o_rsp_data   : a(idx) mod 2^WIDTH
//   o_rsp_id     : id of the requester being answered
//   o_busy       : high while computing or holding a response
module seq_request_scheduler
    import seq_sched_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = 32,
    parameter  int IDX_W   = 8,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [NUM_REQ-1:0]       i_req_valid,
    input  logic [NUM_REQ*IDX_W-1:0] i_req_idx,
    output logic [NUM_REQ-1:0]       o_req_ready,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [WIDTH-1:0]         o_rsp_data,
    output logic [ID_W-1:0]          o_rsp_id,
    output logic                     o_busy
);

    state_t           r_state;
    logic [ID_W-1:0]  r_rr_ptr;
    logic [ID_W-1:0]  r_cur_id;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_cnt;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_data;
    logic [ID_W-1:0]  r_rsp_id;

    logic [IDX_W-1:0] w_req_idx_arr [NUM_REQ];
    logic             w_grant_any;
    logic [ID_W-1:0]  w_grant_id;
    logic [ID_W-1:0]  w_rr_next;
    logic [ID_W:0]    w_cand;
    logic             w_load;
    logic             w_step;
    logic [WIDTH-1:0] w_term;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_idx
            assign w_req_idx_arr[gi] = i_req_idx[gi*IDX_W +: IDX_W];
        end
    endgenerate

    // Search from r_rr_ptr upwards, wrapping at NUM_REQ; one extra bit on
    // the candidate keeps the wrap correct for non-power-of-two NUM_REQ.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_id  = '0;
        w_cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
            if (w_cand >= (ID_W+1)'(NUM_REQ)) begin
                w_cand = w_cand - (ID_W+1)'(NUM_REQ);
            end
            if (!w_grant_any && i_req_valid[w_cand[ID_W-1:0]]) begin
                w_grant_any = 1'b1;
                w_grant_id  = w_cand[ID_W-1:0];
            end
        end
    end

    assign w_rr_next = (w_grant_id == ID_W'(NUM_REQ-1)) ? '0 : w_grant_id + 1'b1;

    // Grant is forced low while reset is asserted so no handshake is seen.
    assign o_req_ready = (r_state == IDLE && w_grant_any && !i_reset)
                         ? (NUM_REQ'(1) << w_grant_id) : '0;

    assign w_load = (r_state == IDLE) && w_grant_any;
    assign w_step = (r_state == RUN) && (r_cnt != r_idx);

    seq_step_engine #(.WIDTH(WIDTH)) u_engine (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (w_load),
        .i_step  (w_step),
        .o_term  (w_term)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_cur_id    <= '0;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_any) begin
                        r_idx    <= w_req_idx_arr[w_grant_id];
                        r_cur_id <= w_grant_id;
                        r_rr_ptr <= w_rr_next;
                        r_cnt    <= '0;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    // Window head equals a(cnt); stop once cnt reaches idx.
                    if (r_cnt == r_idx) begin
                        r_rsp_data  <= w_term;
                        r_rsp_id    <= r_cur_id;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_id    = r_rsp_id;
    assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_seq_request_scheduler.sv
module tb_seq_request_scheduler;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_idx;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_id;
    logic        busy;

    logic [1:0]  req_valid_b;
    logic [15:0] req_idx_b;
    logic [1:0]  req_ready_b;
    logic        rsp_valid_b;
    logic        rsp_ready_b;
    logic [7:0]  rsp_data_b;
    logic [0:0]  rsp_id_b;
    logic        busy_b;

    int n_checks = 0;
    int n_err    = 0;
    int mp       = 0;   // model round-robin pointer

    seq_request_scheduler #(.NUM_REQ(4), .WIDTH(32), .IDX_W(8)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_req_valid (req_valid),
        .i_req_idx   (req_idx),
        .o_req_ready (req_ready),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_data  (rsp_data),
        .o_rsp_id    (rsp_id),
        .o_busy      (busy)
    );

    seq_request_scheduler #(.NUM_REQ(2), .WIDTH(8), .IDX_W(8)) dut8 (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_req_valid (req_valid_b),
        .i_req_idx   (req_idx_b),
        .o_req_ready (req_ready_b),
        .o_rsp_valid (rsp_valid_b),
        .i_rsp_ready (rsp_ready_b),
        .o_rsp_data  (rsp_data_b),
        .o_rsp_id    (rsp_id_b),
        .o_busy      (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int id;
        int idx;
        int exp_data;
        int exp_lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Sequence terms from the recurrence, wrapping at 2^32.
    function automatic logic [31:0] model_term(input int n);
        logic [31:0] t [0:255];
        t[0] = 32'd0;
        t[1] = 32'd1;
        t[2] = 32'd1;
        for (int k = 3; k <= n; k++) t[k] = t[k-2] + t[k-3];
        return t[n];
    endfunction

    // First valid requester at or after the model pointer.
    function automatic int pred_grant();
        for (int k = 0; k < 4; k++) begin
            if (req_valid[(mp + k) % 4]) return (mp + k) % 4;
        end
        return -1;
    endfunction

    task automatic set_req(input int id, input int idx);
        req_valid[id] = 1'b1;
        req_idx[id*8 +: 8] = 8'(idx);
    endtask

    // Called at posedge+1 in IDLE with inputs already applied.
    task automatic transact(input int exp_id, input int exp_data, input int exp_lat, input int rdy_delay);
        int lat;
        #1;
        chk("grant", {60'd0, req_ready}, 64'(1) << exp_id);
        @(posedge clk); #1;
        req_valid[exp_id] = 1'b0;
        req_idx[exp_id*8 +: 8] = 8'($urandom);
        chk("ready_low_run", {60'd0, req_ready}, 64'd0);
        chk("busy_run", {63'd0, busy}, 64'd1);
        lat = 0;
        while (!rsp_valid && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("rsp_data", {32'd0, rsp_data}, 64'(unsigned'(exp_data)));
        chk("rsp_id", {62'd0, rsp_id}, 64'(exp_id));
        for (int d = 0; d < rdy_delay; d++) begin
            @(posedge clk); #1;
            chk("hold_valid", {63'd0, rsp_valid}, 64'd1);
            chk("hold_data", {32'd0, rsp_data}, 64'(unsigned'(exp_data)));
            chk("hold_id", {62'd0, rsp_id}, 64'(exp_id));
            chk("hold_no_grant", {60'd0, req_ready}, 64'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_valid_clear", {63'd0, rsp_valid}, 64'd0);
        chk("busy_idle", {63'd0, busy}, 64'd0);
        mp = (exp_id + 1) % 4;
        $display("txn id=%0d data=%0d lat=%0d", exp_id, exp_data, exp_lat);
    endtask

    task automatic transact8(input int id, input int idx, input int exp_data);
        int lat;
        req_valid_b[id] = 1'b1;
        req_idx_b[id*8 +: 8] = 8'(idx);
        #1;
        chk("w8_grant", {62'd0, req_ready_b}, 64'(1) << id);
        @(posedge clk); #1;
        req_valid_b = 2'b00;
        lat = 0;
        while (!rsp_valid_b && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("w8_latency", 64'(lat), 64'(idx + 1));
        chk("w8_data", {56'd0, rsp_data_b}, 64'(exp_data));
        chk("w8_id", {63'd0, rsp_id_b}, 64'(id));
        rsp_ready_b = 1'b1;
        @(posedge clk); #1;
        rsp_ready_b = 1'b0;
        chk("w8_clear", {63'd0, rsp_valid_b}, 64'd0);
        $display("txn8 id=%0d idx=%0d data=%0d", id, idx, exp_data);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        mp = 0;
    endtask

    initial begin
        vec_t vecs [6];
        int   quiet_bad;
        int   g;
        int   idx;

        vecs[0] = '{0, 15, 37, 16};
        vecs[1] = '{1, 0, 0, 1};
        vecs[2] = '{2, 3, 1, 4};
        vecs[3] = '{3, 10, 9, 11};
        vecs[4] = '{0, 12, 16, 13};
        vecs[5] = '{2, 22, 265, 23};

        reset       = 1'b1;
        req_valid   = 4'h0;
        req_idx     = '0;
        rsp_ready   = 1'b0;
        req_valid_b = 2'b00;
        req_idx_b   = '0;
        rsp_ready_b = 1'b0;

        // Reset state, with all requests asserted: no grant may show.
        #3;
        req_valid = 4'hF;
        #1;
        chk("rst_req_ready", {60'd0, req_ready}, 64'd0);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_rsp_data", {32'd0, rsp_data}, 64'd0);
        chk("rst_rsp_id", {62'd0, rsp_id}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        req_valid = 4'h0;
        @(posedge clk); #1;
        reset = 1'b0;

        // Single-request vectors.
        for (int i = 0; i < 6; i++) begin
            set_req(vecs[i].id, vecs[i].idx);
            transact(vecs[i].id, vecs[i].exp_data, vecs[i].exp_lat, i % 2);
        end

        // All four at once from pointer 0: served in id order.
        do_reset();
        set_req(0, 5); set_req(1, 6); set_req(2, 7); set_req(3, 8);
        transact(0, 2, 6, 0);
        transact(1, 3, 7, 0);
        transact(2, 4, 8, 0);
        transact(3, 5, 9, 0);

        // Fairness: after 1 is served, 2 wins over 0; response held 3 cycles.
        set_req(1, 4);
        transact(1, 2, 5, 0);
        set_req(0, 9); set_req(2, 11);
        transact(2, 12, 12, 3);
        transact(0, 7, 10, 0);

        // Reset mid-RUN: outputs drop immediately, no response follows.
        set_req(3, 60);
        #1;
        chk("mid_grant", {60'd0, req_ready}, 64'd8);
        @(posedge clk); #1;
        req_valid = 4'h0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_busy", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("mid_rst_rsp_data", {32'd0, rsp_data}, 64'd0);
        chk("mid_rst_rsp_id", {62'd0, rsp_id}, 64'd0);
        req_valid = 4'hF;
        #1;
        chk("mid_rst_req_ready", {60'd0, req_ready}, 64'd0);
        req_valid = 4'h0;
        @(posedge clk); #1;
        reset = 1'b0;
        mp = 0;
        quiet_bad = 0;
        for (int c = 0; c < 70; c++) begin
            @(posedge clk); #1;
            if (rsp_valid || busy) quiet_bad++;
        end
        chk("no_rsp_after_reset", 64'(quiet_bad), 64'd0);
        for (int i = 0; i < 4; i++) set_req(i, 20 + i);
        transact(0, model_term(20), 21, 0);

        // Randomized traffic against the reference model.
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < 4; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    set_req(i, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255)
                                                           : $urandom_range(0, 30));
                end
            end
            if (req_valid == 4'h0) set_req($urandom_range(0, 3), $urandom_range(0, 30));
            g   = pred_grant();
            idx = int'(req_idx[g*8 +: 8]);
            transact(g, model_term(idx), idx + 1, $urandom_range(0, 2));
        end

        // Narrow datapath wrap-around.
        transact8(0, 22, 9);
        transact8(1, 40, int'(model_term(40) & 32'hFF));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
